// File: rtl/detector_scheduler_if.sv
// detector_scheduler_if: request/data/grant bundle, detector link and frame status
// for detector_scheduler. The slave modport is the scheduler's view; master is the
// view of whatever drives the requests and hosts the serial detector.
interface detector_scheduler_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) ();

   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic             gnt0;
   logic             gnt1;
   logic             det_inp;
   logic             det_rst;
   logic [1:0]       det_out;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [CNT_W-1:0] cnt01;
   logic [CNT_W-1:0] cnt10;
   logic [CNT_W-1:0] cnt11;

   modport slave (
      input  req0, req1, data0, data1, det_out,
      output gnt0, gnt1, det_inp, det_rst, busy, done, done_id, cnt01, cnt10, cnt11
   );

   modport master (
      output req0, req1, data0, data1, det_out,
      input  gnt0, gnt1, det_inp, det_rst, busy, done, done_id, cnt01, cnt10, cnt11
   );

endinterface

// File: rtl/detector_scheduler.sv
// detector_scheduler: shares one serial sequence detector between two word producers.
// A granted word is captured, the detector is cleared for one cycle, the word is
// shifted out LSB first, and nonzero detector codes are tallied per frame.
// Build option: define DETSCHED_RR_EN for round-robin arbitration; otherwise req0
// has fixed priority on a tie.
module detector_scheduler #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   detector_scheduler_if.slave  bus_io
);

   localparam int unsigned BitCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StShift,
      StDrain,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
   logic               id_q, id_d;
   logic               last_id_q, last_id_d;
   logic               done_id_q, done_id_d;
   logic [CNT_W-1:0]   cnt01_q, cnt01_d;
   logic [CNT_W-1:0]   cnt10_q, cnt10_d;
   logic [CNT_W-1:0]   cnt11_q, cnt11_d;

   logic pick1;
   logic in_idle;
   logic grant;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CntMax) ? v : v + 1'b1;
   endfunction

   // Arbitration: decide which requester would win if a grant were issued now
   always_comb begin
`ifdef DETSCHED_RR_EN
      // On a tie the requester that was not served last wins
      pick1 = bus_io.req1 & (~bus_io.req0 | ~last_id_q);
`else
      pick1 = bus_io.req1 & ~bus_io.req0;
`endif
   end

`ifndef DETSCHED_RR_EN
   // last_id is tracked in both builds but only steers arbitration in round-robin mode
   logic unused_last_id;
   assign unused_last_id = last_id_q;
`endif

   // Grants are combinational and only live in an idle, non-reset cycle
   always_comb begin
      in_idle     = ~rst & (state_q == StIdle);
      bus_io.gnt0 = in_idle & (bus_io.req0 | bus_io.req1) & ~pick1;
      bus_io.gnt1 = in_idle & pick1;
      grant       = bus_io.gnt0 | bus_io.gnt1;
   end

   // Next-state and datapath updates for one frame
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      id_d      = id_q;
      last_id_d = last_id_q;
      done_id_d = done_id_q;
      cnt01_d   = cnt01_q;
      cnt10_d   = cnt10_q;
      cnt11_d   = cnt11_q;

      unique case (state_q)
         StIdle: begin
            if (grant) begin
               shreg_d   = pick1 ? bus_io.data1 : bus_io.data0;
               id_d      = pick1;
               last_id_d = pick1;
               state_d   = StClr;
            end
         end
         StClr: begin
            cnt01_d   = '0;
            cnt10_d   = '0;
            cnt11_d   = '0;
            bit_cnt_d = '0;
            state_d   = StShift;
         end
         StShift: begin
            shreg_d = shreg_q >> 1;
            unique case (bus_io.det_out)
               2'b01:   cnt01_d = sat_inc(cnt01_q);
               2'b10:   cnt10_d = sat_inc(cnt10_q);
               2'b11:   cnt11_d = sat_inc(cnt11_q);
               default: ;
            endcase
            if (bit_cnt_q == LastBit) begin
               state_d = StDrain;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         StDrain: begin
            // The detector reports the last shifted bit one cycle late, so sample here too
            unique case (bus_io.det_out)
               2'b01:   cnt01_d = sat_inc(cnt01_q);
               2'b10:   cnt10_d = sat_inc(cnt10_q);
               2'b11:   cnt11_d = sat_inc(cnt11_q);
               default: ;
            endcase
            done_id_d = id_q;
            state_d   = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         id_q      <= 1'b0;
         last_id_q <= 1'b1;
         done_id_q <= 1'b0;
         cnt01_q   <= '0;
         cnt10_q   <= '0;
         cnt11_q   <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         id_q      <= id_d;
         last_id_q <= last_id_d;
         done_id_q <= done_id_d;
         cnt01_q   <= cnt01_d;
         cnt10_q   <= cnt10_d;
         cnt11_q   <= cnt11_d;
      end
   end

   // Status and detector drive decoded from the registered state
   always_comb begin
      bus_io.det_rst = rst | (state_q == StClr);
      bus_io.det_inp = ~rst & (state_q == StShift) & shreg_q[0];
      bus_io.busy    = ~rst & (state_q != StIdle);
      bus_io.done    = ~rst & (state_q == StDone);
      bus_io.done_id = done_id_q;
      bus_io.cnt01   = cnt01_q;
      bus_io.cnt10   = cnt10_q;
      bus_io.cnt11   = cnt11_q;
   end

endmodule

// File: tb/tb_detector_scheduler.sv
// tb_detector_scheduler: directed and random frames through detector_scheduler with
// a small run-length detector attached (code 01/10/11 for a run of 1/2/3+ ones ended
// by a zero, reported one cycle after that zero).
module tb_detector_scheduler;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 2;
`ifdef DETSCHED_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   bit   m_last = 1'b1;

   detector_scheduler_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   detector_scheduler #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // Serial detector model
   int unsigned det_run = 0;
   logic [1:0]  det_q = 2'b00;
   always @(posedge clk) begin
      if (bus.det_rst) begin
         det_run <= 0;
         det_q   <= 2'b00;
      end else if (bus.det_inp) begin
         det_run <= det_run + 1;
         det_q   <= 2'b00;
      end else begin
         det_q   <= (det_run == 0) ? 2'd0 : (det_run == 1) ? 2'd1 : (det_run == 2) ? 2'd2 : 2'd3;
         det_run <= 0;
      end
   end
   assign bus.det_out = det_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected tallies: every zero that closes a run of ones contributes one hit
   function automatic void exp_counts(input logic [W-1:0] w, output int unsigned c1,
                                      output int unsigned c2, output int unsigned c3);
      int unsigned run = 0;
      int unsigned cmax = (1 << CW) - 1;
      c1 = 0; c2 = 0; c3 = 0;
      for (int i = 0; i < W; i++) begin
         if (w[i]) run++;
         else begin
            if (run == 1) c1++;
            else if (run == 2) c2++;
            else if (run >= 3) c3++;
            run = 0;
         end
      end
      if (c1 > cmax) c1 = cmax;
      if (c2 > cmax) c2 = cmax;
      if (c3 > cmax) c3 = cmax;
   endfunction

   task automatic frame(input bit r0, input bit r1, input logic [W-1:0] d0,
                        input logic [W-1:0] d1, input bit hold);
      bit win;
      logic [W-1:0] w;
      int unsigned e1, e2, e3;
      int lat;
      win = (r0 && r1) ? (RR ? ~m_last : 1'b0) : r1;
      w = win ? d1 : d0;
      @(negedge clk);
      bus.req0 = r0; bus.req1 = r1; bus.data0 = d0; bus.data1 = d1;
      #1;
      check("idle_done", bus.done, 1'b0);
      check("idle_busy", bus.busy, 1'b0);
      check("gnt0", bus.gnt0, !win);
      check("gnt1", bus.gnt1, win);
      m_last = win;
      @(negedge clk);
      if (!hold) begin
         bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      #1;
      check("clr_gnt", bus.gnt0 | bus.gnt1, 1'b0);
      check("clr_det_rst", bus.det_rst, 1'b1);
      check("clr_busy", bus.busy, 1'b1);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 30) begin
         @(negedge clk); #1;
         lat++;
         if (lat >= 2 && lat <= W + 1) check("shift_bit", bus.det_inp, w[lat-2]);
         if (lat == W + 2) check("drain_bit", bus.det_inp, 1'b0);
      end
      check("latency", lat, W + 3);
      exp_counts(w, e1, e2, e3);
      check("cnt01", bus.cnt01, e1);
      check("cnt10", bus.cnt10, e2);
      check("cnt11", bus.cnt11, e3);
      check("done_id", bus.done_id, win);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [1:0] r;
      bus.req0 = 1'b1; bus.req1 = 1'b0; bus.data0 = '1; bus.data1 = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_gnt0", bus.gnt0, 1'b0);
      check("rst_det_inp", bus.det_inp, 1'b0);
      check("rst_det_rst", bus.det_rst, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_done_id", bus.done_id, 1'b0);
      check("rst_cnts", {bus.cnt01, bus.cnt10, bus.cnt11}, 0);
      @(negedge clk);
      rst = 1'b0; bus.req0 = 1'b0;
      m_last = 1'b1;

      frame(1'b1, 1'b0, 8'b0000_0010, 8'h00, 1'b0);
      frame(1'b1, 1'b0, 8'b0000_0110, 8'h00, 1'b0);
      frame(1'b0, 1'b1, 8'h00, 8'b0000_1110, 1'b0);

      // Both requests held across three back-to-back frames
      for (int k = 0; k < 3; k++) frame(1'b1, 1'b1, 8'b0000_0010, 8'b0000_0110, 1'b1);
      @(negedge clk);
      bus.req0 = 1'b0; bus.req1 = 1'b0;

      // Four isolated single-one runs saturate a 2-bit counter at 3
      frame(1'b1, 1'b0, 8'b0101_0101, 8'h00, 1'b0);

      // Reset in the middle of SHIFT
      @(negedge clk);
      bus.req0 = 1'b1; bus.data0 = 8'b0011_0110;
      #1;
      check("mid_gnt0", bus.gnt0, 1'b1);
      @(negedge clk);
      bus.req0 = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_det_rst", bus.det_rst, 1'b1);
      check("mid_done", bus.done, 1'b0);
      @(negedge clk); #1;
      check("post_rst_busy", bus.busy, 1'b0);
      check("post_rst_cnts", {bus.cnt01, bus.cnt10, bus.cnt11}, 0);
      check("post_rst_det_rst", bus.det_rst, 1'b1);
      rst = 1'b0;
      m_last = 1'b1;
      pulses = 0;
      repeat (15) begin
         @(negedge clk); #1;
         if (bus.done === 1'b1) pulses++;
      end
      check("mid_no_done", pulses, 0);
      frame(1'b1, 1'b1, 8'b1011_0111, 8'b0100_1101, 1'b0);

      // Random frames
      for (int k = 0; k < 20; k++) begin
         r = 2'($urandom_range(1, 3));
         frame(r[0], r[1], W'($urandom), W'($urandom), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
